// File: rtl/eeg_wram_mb.sv
// Multi-bank weight RAM controller between config sequencer and PE engines.
// Runs one command at a time: per-bank write, broadcast write, read, conv read.
module eeg_wram_mb #(
  parameter int NUM_BANK = 4,
  parameter int ADD_AW   = 13,
  parameter int DAT_DW   = 8,
  parameter int CMD_DW   = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  output logic                         IS_IDLE,
  input  logic                         CFG_INFO_VLD,
  output logic                         CFG_INFO_RDY,
  input  logic [CMD_DW-1:0]            CFG_INFO_CMD,
  input  logic [NUM_BANK-1:0]          CFG_BANK_MSK,
  output logic                         CMD_ERR,
  input  logic [NUM_BANK-1:0]          ETOW_DAT_VLD,
  input  logic [NUM_BANK-1:0]          ETOW_DAT_LST,
  output logic [NUM_BANK-1:0]          ETOW_DAT_RDY,
  input  logic [NUM_BANK*ADD_AW-1:0]   ETOW_DAT_ADD,
  input  logic [NUM_BANK*DAT_DW-1:0]   ETOW_DAT_DAT,
  input  logic [NUM_BANK-1:0]          ETOW_ADD_VLD,
  input  logic [NUM_BANK-1:0]          ETOW_ADD_LST,
  output logic [NUM_BANK-1:0]          ETOW_ADD_RDY,
  input  logic [NUM_BANK*ADD_AW-1:0]   ETOW_ADD_ADD,
  output logic [NUM_BANK-1:0]          WTOE_DAT_VLD,
  output logic [NUM_BANK-1:0]          WTOE_DAT_LST,
  input  logic [NUM_BANK-1:0]          WTOE_DAT_RDY,
  output logic [NUM_BANK*DAT_DW-1:0]   WTOE_DAT_DAT
);

  localparam int DEPTH = 2 ** ADD_AW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_BCAST,
    S_READ,
    S_CONV
  } state_t;

  state_t st, st_nxt, cmd_st;

  logic [NUM_BANK-1:0] msk, done, done_set, done_nxt;
  logic [NUM_BANK-1:0] lst_iss;
  logic [NUM_BANK-1:0] wr_hs, add_hs, rd_hs;
  logic [NUM_BANK-1:0] wp, rp;
  logic [1:0]          occ [NUM_BANK];
  logic                acc, legal, cmd_err, rd_mode;

  logic [DAT_DW-1:0]   mem  [NUM_BANK][DEPTH];
  logic [DAT_DW-1:0]   fdat [NUM_BANK][2];
  logic                flst [NUM_BANK][2];

  logic [NUM_BANK-1:0] mem_we;
  logic [ADD_AW-1:0]   mem_wa [NUM_BANK];
  logic [DAT_DW-1:0]   mem_wd [NUM_BANK];
  logic [ADD_AW-1:0]   mem_ra [NUM_BANK];

  assign IS_IDLE      = (st == S_IDLE);
  assign CFG_INFO_RDY = IS_IDLE;
  assign CMD_ERR      = cmd_err;
  assign acc          = CFG_INFO_VLD & CFG_INFO_RDY;
  assign rd_mode      = (st == S_READ) || (st == S_CONV);

  always_comb begin
    cmd_st = S_IDLE;
    legal  = 1'b0;
    unique case (CFG_INFO_CMD)
      CMD_DW'(1): begin cmd_st = S_WRITE; legal = 1'b1; end
      CMD_DW'(2): begin cmd_st = S_BCAST; legal = 1'b1; end
      CMD_DW'(3): begin cmd_st = S_READ;  legal = 1'b1; end
      CMD_DW'(4): begin cmd_st = S_CONV;  legal = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    ETOW_DAT_RDY = '0;
    if (st == S_WRITE)
      ETOW_DAT_RDY = msk & ~done;
    else if (st == S_BCAST)
      ETOW_DAT_RDY[0] = ~&done;
  end

  always_comb begin
    ETOW_ADD_RDY = '0;
    WTOE_DAT_VLD = '0;
    WTOE_DAT_LST = '0;
    WTOE_DAT_DAT = '0;
    for (int i = 0; i < NUM_BANK; i++) begin
      mem_ra[i] = ETOW_ADD_ADD[i*ADD_AW +: ADD_AW];
      if (rd_mode) begin
        ETOW_ADD_RDY[i] = msk[i] & ~lst_iss[i] & (occ[i] < 2'd2);
        WTOE_DAT_VLD[i] = (occ[i] != 2'd0);
      end
      if (WTOE_DAT_VLD[i]) begin
        WTOE_DAT_LST[i] = flst[i][rp[i]];
        WTOE_DAT_DAT[i*DAT_DW +: DAT_DW] = fdat[i][rp[i]];
      end
    end
  end

  assign wr_hs  = ETOW_DAT_VLD & ETOW_DAT_RDY;
  assign add_hs = ETOW_ADD_VLD & ETOW_ADD_RDY;
  assign rd_hs  = WTOE_DAT_VLD & WTOE_DAT_RDY;

  // Broadcast takes bank 0's beat and fans it out to every masked bank.
  always_comb begin
    for (int i = 0; i < NUM_BANK; i++) begin
      if (st == S_BCAST) begin
        mem_we[i] = wr_hs[0] & msk[i];
        mem_wa[i] = ETOW_DAT_ADD[0 +: ADD_AW];
        mem_wd[i] = ETOW_DAT_DAT[0 +: DAT_DW];
      end else begin
        mem_we[i] = wr_hs[i];
        mem_wa[i] = ETOW_DAT_ADD[i*ADD_AW +: ADD_AW];
        mem_wd[i] = ETOW_DAT_DAT[i*DAT_DW +: DAT_DW];
      end
    end
  end

  always_comb begin
    done_set = '0;
    unique case (st)
      S_WRITE: done_set = wr_hs & ETOW_DAT_LST;
      S_BCAST: done_set = {NUM_BANK{wr_hs[0] & ETOW_DAT_LST[0]}};
      S_READ,
      S_CONV:  done_set = rd_hs & WTOE_DAT_LST;
      default: ;
    endcase
    done_nxt = done | done_set;
  end

  always_comb begin
    st_nxt = st;
    unique case (st)
      S_IDLE:  if (acc && legal) st_nxt = cmd_st;
      default: if (&done_nxt) st_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= S_IDLE;
      msk     <= '0;
      done    <= '1;
      lst_iss <= '0;
      cmd_err <= 1'b0;
      wp      <= '0;
      rp      <= '0;
      for (int i = 0; i < NUM_BANK; i++) occ[i] <= 2'd0;
    end else begin
      st      <= st_nxt;
      cmd_err <= acc & ~legal;
      if (acc && legal) begin
        msk     <= (cmd_st == S_CONV) ? '1 : CFG_BANK_MSK;
        done    <= (cmd_st == S_CONV) ? '0 : ~CFG_BANK_MSK;
        lst_iss <= '0;
      end else begin
        done    <= done_nxt;
        lst_iss <= lst_iss | (add_hs & ETOW_ADD_LST);
      end
      wp <= wp ^ add_hs;
      rp <= rp ^ rd_hs;
      for (int i = 0; i < NUM_BANK; i++)
        occ[i] <= occ[i] + {1'b0, add_hs[i]} - {1'b0, rd_hs[i]};
    end
  end

  // Registered RAM port lands straight in the FIFO slot.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_BANK; i++) begin
      if (mem_we[i]) mem[i][mem_wa[i]] <= mem_wd[i];
      if (add_hs[i]) begin
        fdat[i][wp[i]] <= mem[i][mem_ra[i]];
        flst[i][wp[i]] <= ETOW_ADD_LST[i];
      end
    end
  end

endmodule

// File: tb/tb_eeg_wram_mb.sv
// Directed bench for eeg_wram_mb: write/read, broadcast, conv,
// backpressure, illegal and empty-mask commands, async reset.
module tb_eeg_wram_mb;

  localparam int NB = 4;
  localparam int AW = 13;
  localparam int DW = 8;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic is_idle, cfg_rdy, cmd_err;
  logic cfg_vld;
  logic [CW-1:0] cfg_cmd;
  logic [NB-1:0] cfg_msk;
  logic [NB-1:0] wd_vld, wd_lst, wd_rdy;
  logic [NB*AW-1:0] wd_add;
  logic [NB*DW-1:0] wd_dat;
  logic [NB-1:0] ra_vld, ra_lst, ra_rdy;
  logic [NB*AW-1:0] ra_add;
  logic [NB-1:0] rd_vld, rd_lst, rd_rdy;
  logic [NB*DW-1:0] rd_dat;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  eeg_wram_mb #(
    .NUM_BANK(NB), .ADD_AW(AW), .DAT_DW(DW), .CMD_DW(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .IS_IDLE(is_idle),
    .CFG_INFO_VLD(cfg_vld), .CFG_INFO_RDY(cfg_rdy),
    .CFG_INFO_CMD(cfg_cmd), .CFG_BANK_MSK(cfg_msk),
    .CMD_ERR(cmd_err),
    .ETOW_DAT_VLD(wd_vld), .ETOW_DAT_LST(wd_lst),
    .ETOW_DAT_RDY(wd_rdy), .ETOW_DAT_ADD(wd_add),
    .ETOW_DAT_DAT(wd_dat),
    .ETOW_ADD_VLD(ra_vld), .ETOW_ADD_LST(ra_lst),
    .ETOW_ADD_RDY(ra_rdy), .ETOW_ADD_ADD(ra_add),
    .WTOE_DAT_VLD(rd_vld), .WTOE_DAT_LST(rd_lst),
    .WTOE_DAT_RDY(rd_rdy), .WTOE_DAT_DAT(rd_dat)
  );

  task automatic send_cmd(input logic [CW-1:0] c,
                          input logic [NB-1:0] m);
    @(negedge clk);
    cfg_vld = 1'b1;
    cfg_cmd = c;
    cfg_msk = m;
    @(negedge clk);
    cfg_vld = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    tests++;
    if (is_idle !== 1'b1 || cfg_rdy !== 1'b1 || cmd_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctrl idle=%b rdy=%b err=%b want 1 1 0",
               is_idle, cfg_rdy, cmd_err);
    end
    tests++;
    if (wd_rdy !== 4'h0 || ra_rdy !== 4'h0 || rd_vld !== 4'h0 ||
        rd_lst !== 4'h0 || rd_dat !== '0) begin
      fails++;
      $display("FAIL reset_streams wrdy=%b ardy=%b vld=%b lst=%b dat=%h want 0",
               wd_rdy, ra_rdy, rd_vld, rd_lst, rd_dat);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write;
    send_cmd(3'd1, 4'b0101);
    tests++;
    if (wd_rdy !== 4'b0101 || is_idle !== 1'b0) begin
      fails++;
      $display("FAIL write_start rdy=%b idle=%b want 0101 0", wd_rdy, is_idle);
    end
    for (int k = 0; k < 5; k++) begin
      wd_vld = '0;
      wd_lst = '0;
      if (k < 4) begin
        wd_vld[0] = 1'b1;
        wd_add[0*AW +: AW] = AW'(k);
        wd_dat[0*DW +: DW] = DW'(8'h10 + k);
        wd_lst[0] = (k == 3);
      end
      if (k >= 1) begin
        wd_vld[2] = 1'b1;
        wd_add[2*AW +: AW] = AW'(k - 1);
        wd_dat[2*DW +: DW] = DW'(8'h20 + k - 1);
        wd_lst[2] = (k == 4);
      end
      if (k == 4) begin
        tests++;
        if (wd_rdy !== 4'b0100) begin
          fails++;
          $display("FAIL write_bank0_done rdy=%b want 0100", wd_rdy);
        end
      end
      @(negedge clk);
    end
    wd_vld = '0;
    wd_lst = '0;
    tests++;
    if (is_idle !== 1'b1 || wd_rdy !== 4'h0) begin
      fails++;
      $display("FAIL write_end idle=%b rdy=%b want 1 0000", is_idle, wd_rdy);
    end
  endtask

  task automatic test_read;
    rd_rdy = 4'hF;
    send_cmd(3'd3, 4'b0101);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        tests++;
        if (rd_vld !== 4'b0101 ||
            rd_dat[0*DW +: DW] !== DW'(8'h10 + k - 1) ||
            rd_dat[2*DW +: DW] !== DW'(8'h20 + k - 1) ||
            rd_lst !== ((k == 4) ? 4'b0101 : 4'b0000)) begin
          fails++;
          $display("FAIL read_beat%0d vld=%b lst=%b d0=%h d2=%h want 0101 %0d %h %h",
                   k, rd_vld, rd_lst, rd_dat[0*DW +: DW],
                   rd_dat[2*DW +: DW], (k == 4),
                   8'h10 + k - 1, 8'h20 + k - 1);
        end
      end
      if (k < 4) begin
        tests++;
        if (ra_rdy !== 4'b0101) begin
          fails++;
          $display("FAIL read_add_rdy%0d rdy=%b want 0101", k, ra_rdy);
        end
        ra_vld = 4'b0101;
        ra_add[0*AW +: AW] = AW'(k);
        ra_add[2*AW +: AW] = AW'(k);
        ra_lst = (k == 3) ? 4'b0101 : 4'b0000;
      end else begin
        ra_vld = '0;
        ra_lst = '0;
        tests++;
        if (ra_rdy !== 4'b0000 || is_idle !== 1'b0) begin
          fails++;
          $display("FAIL read_lst_issued rdy=%b idle=%b want 0000 0",
                   ra_rdy, is_idle);
        end
      end
      @(negedge clk);
    end
    tests++;
    if (is_idle !== 1'b1 || rd_vld !== 4'h0) begin
      fails++;
      $display("FAIL read_end idle=%b vld=%b want 1 0000", is_idle, rd_vld);
    end
  endtask

  task automatic test_bcast_conv;
    send_cmd(3'd2, 4'b1111);
    tests++;
    if (wd_rdy !== 4'b0001) begin
      fails++;
      $display("FAIL bcast_rdy rdy=%b want 0001", wd_rdy);
    end
    wd_vld = 4'b0001;
    wd_lst = 4'b0001;
    wd_add[0 +: AW] = AW'(100);
    wd_dat[0 +: DW] = 8'hA5;
    @(negedge clk);
    wd_vld = '0;
    wd_lst = '0;
    tests++;
    if (is_idle !== 1'b1) begin
      fails++;
      $display("FAIL bcast_end idle=%b want 1", is_idle);
    end
    rd_rdy = 4'hF;
    send_cmd(3'd4, 4'b0000);
    tests++;
    if (ra_rdy !== 4'b1111) begin
      fails++;
      $display("FAIL conv_add_rdy rdy=%b want 1111", ra_rdy);
    end
    ra_vld = 4'hF;
    ra_lst = 4'hF;
    for (int b = 0; b < NB; b++) ra_add[b*AW +: AW] = AW'(100);
    @(negedge clk);
    ra_vld = '0;
    ra_lst = '0;
    tests++;
    if (rd_vld !== 4'hF || rd_lst !== 4'hF || rd_dat !== 32'hA5A5A5A5 ||
        is_idle !== 1'b0) begin
      fails++;
      $display("FAIL conv_data vld=%b lst=%b dat=%h idle=%b want 1111 1111 a5a5a5a5 0",
               rd_vld, rd_lst, rd_dat, is_idle);
    end
    @(negedge clk);
    tests++;
    if (is_idle !== 1'b1 || rd_vld !== 4'h0) begin
      fails++;
      $display("FAIL conv_simul_last idle=%b vld=%b want 1 0000",
               is_idle, rd_vld);
    end
  endtask

  task automatic test_cmd_err;
    send_cmd(3'd7, 4'b1111);
    tests++;
    if (cmd_err !== 1'b1 || is_idle !== 1'b1) begin
      fails++;
      $display("FAIL cmd_err_pulse err=%b idle=%b want 1 1", cmd_err, is_idle);
    end
    @(negedge clk);
    tests++;
    if (cmd_err !== 1'b0 || is_idle !== 1'b1) begin
      fails++;
      $display("FAIL cmd_err_clear err=%b idle=%b want 0 1", cmd_err, is_idle);
    end
  endtask

  task automatic test_mask0;
    send_cmd(3'd1, 4'b0000);
    tests++;
    if (is_idle !== 1'b0 || wd_rdy !== 4'h0 || ra_rdy !== 4'h0) begin
      fails++;
      $display("FAIL mask0_active idle=%b wrdy=%b ardy=%b want 0 0000 0000",
               is_idle, wd_rdy, ra_rdy);
    end
    @(negedge clk);
    tests++;
    if (is_idle !== 1'b1) begin
      fails++;
      $display("FAIL mask0_end idle=%b want 1", is_idle);
    end
  endtask

  task automatic test_backpressure;
    int sent, recv, cyc;
    logic hs_a, hs_d;
    send_cmd(3'd1, 4'b0010);
    for (int k = 0; k < 8; k++) begin
      wd_vld = 4'b0010;
      wd_lst = (k == 7) ? 4'b0010 : 4'b0000;
      wd_add[1*AW +: AW] = AW'(k);
      wd_dat[1*DW +: DW] = DW'(8'h30 + k);
      @(negedge clk);
    end
    wd_vld = '0;
    wd_lst = '0;
    send_cmd(3'd3, 4'b0010);
    sent = 0;
    recv = 0;
    cyc = 0;
    while (recv < 8 && cyc < 300) begin
      rd_rdy = '0;
      rd_rdy[1] = (cyc < 4) ? 1'b0 : 1'($urandom_range(0, 1));
      ra_vld = '0;
      ra_lst = '0;
      if (sent < 8) begin
        ra_vld[1] = 1'b1;
        ra_lst[1] = (sent == 7);
        ra_add[1*AW +: AW] = AW'(sent);
      end
      #1;
      if (sent - recv >= 2) begin
        tests++;
        if (ra_rdy[1] !== 1'b0) begin
          fails++;
          $display("FAIL bp_add_rdy pending=%0d rdy=%b want 0",
                   sent - recv, ra_rdy[1]);
        end
      end
      hs_a = ra_vld[1] & ra_rdy[1];
      hs_d = rd_vld[1] & rd_rdy[1];
      if (hs_d) begin
        tests++;
        if (rd_dat[1*DW +: DW] !== DW'(8'h30 + recv) ||
            rd_lst[1] !== (recv == 7)) begin
          fails++;
          $display("FAIL bp_beat%0d dat=%h lst=%b want %h %0d",
                   recv, rd_dat[1*DW +: DW], rd_lst[1],
                   8'h30 + recv, (recv == 7));
        end
        recv++;
      end
      if (hs_a) sent++;
      cyc++;
      @(negedge clk);
    end
    ra_vld = '0;
    ra_lst = '0;
    tests++;
    if (recv != 8) begin
      fails++;
      $display("FAIL bp_timeout beats=%0d want 8", recv);
    end
    tests++;
    if (is_idle !== 1'b1) begin
      fails++;
      $display("FAIL bp_end idle=%b want 1", is_idle);
    end
  endtask

  task automatic test_reset_mid;
    rd_rdy = '0;
    send_cmd(3'd3, 4'b0001);
    for (int k = 0; k < 2; k++) begin
      ra_vld = 4'b0001;
      ra_lst = 4'b0000;
      ra_add[0 +: AW] = AW'(k);
      @(negedge clk);
    end
    ra_vld = '0;
    tests++;
    if (rd_vld !== 4'b0001 || ra_rdy !== 4'b0000) begin
      fails++;
      $display("FAIL rstmid_full vld=%b ardy=%b want 0001 0000", rd_vld, ra_rdy);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (rd_vld !== 4'h0 || ra_rdy !== 4'h0 || is_idle !== 1'b1 ||
        rd_dat !== '0) begin
      fails++;
      $display("FAIL rstmid_async vld=%b ardy=%b idle=%b dat=%h want 0 0 1 0",
               rd_vld, ra_rdy, is_idle, rd_dat);
    end
    @(negedge clk);
    rst_n = 1'b1;
    rd_rdy = 4'hF;
    repeat (3) @(negedge clk);
    tests++;
    if (rd_vld !== 4'h0 || is_idle !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_stale vld=%b idle=%b want 0000 1", rd_vld, is_idle);
    end
  endtask

  initial begin
    cfg_vld = 1'b0;
    cfg_cmd = '0;
    cfg_msk = '0;
    wd_vld = '0;
    wd_lst = '0;
    wd_add = '0;
    wd_dat = '0;
    ra_vld = '0;
    ra_lst = '0;
    ra_add = '0;
    rd_rdy = '0;
    test_reset;
    test_write;
    test_read;
    test_bcast_conv;
    test_cmd_err;
    test_mask0;
    test_backpressure;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
